ucaspian_axon_multi: RTL

// - Parametrised axon stage: maps neuron fires to synapse ranges and applies per-axon delay of 0..2**DELAY_W-1 steps.
// - Sits between the neuron unit (axon_*) and the synapse unit (syn_*); configured by the config decoder.
// - Adds over the previous axon: generic axon count/widths, a full-word config port, an output FIFO decoupling synapse backpressure, and a clear FSM.

---
 rtl/ucaspian_axon_multi.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ucaspian_axon_multi.sv
// Axon stage: maps neuron fires to synapse ranges with per-axon step delays and an output FIFO.
// Define UCASPIAN_AXON_STATS_EN to add the saturating fire_count push counter.
module ucaspian_axon_multi #(
    parameter int NUM_AXONS  = 256,
    parameter int DELAY_W    = 4,
    parameter int SYN_W      = 12,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int AXON_W    = $clog2(NUM_AXONS),
    localparam int DQ_W      = 2**DELAY_W,
    localparam int CFG_W     = DELAY_W + SYN_W + CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_act,
    input  logic              clear_config,
    output logic              clear_done,
    input  logic              cfg_wr_en,
    input  logic [AXON_W-1:0] cfg_addr,
    input  logic [CFG_W-1:0]  cfg_wr_data,
    input  logic              next_step,
    output logic              step_done,
    input  logic [AXON_W-1:0] axon_addr,
    input  logic              axon_vld,
    output logic              axon_rdy,
    output logic [SYN_W-1:0]  syn_start,
    output logic [SYN_W-1:0]  syn_end,
    output logic              syn_vld,
    input  logic              syn_rdy
`ifdef UCASPIAN_AXON_STATS_EN
    ,
    output logic [15:0]       fire_count
`endif
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CLEAR, CLEAR_DONE} state_t;
    state_t state, state_nxt;

    logic [CFG_W-1:0]  cfg_ram [NUM_AXONS];
    logic [DQ_W-1:0]   dq_ram  [NUM_AXONS];

    logic [AXON_W-1:0] scan_idx, clr_idx, iss_addr;
    logic              clr_cfg, clear_req, in_clear, clr_entry, clr_restart;
    logic              room, fire_acc, scan_iss, iss_vld, last_scan, drain_idle;

    logic              s1_vld, s1_fire, s1_passed, s1_push;
    logic [AXON_W-1:0] s1_addr;
    logic [CFG_W-1:0]  s1_cfg;
    logic [DQ_W-1:0]   s1_dq, s1_dq_new;
    logic [DELAY_W-1:0] s1_delay;
    logic [SYN_W-1:0]  s1_first;
    logic [CNT_W-1:0]  s1_cnt;

    logic              s2_vld;
    logic [SYN_W-1:0]  s2_start, s2_end;

    logic [SYN_W-1:0]  f_start [FIFO_DEPTH];
    logic [SYN_W-1:0]  f_end   [FIFO_DEPTH];
    logic [PTR_W-1:0]  f_wr, f_rd;
    logic [FCNT_W-1:0] f_cnt;
    logic              f_pop;

    assign clear_req   = clear_act | clear_config;
    assign in_clear    = (state == CLEAR) || (state == CLEAR_DONE);
    assign clr_entry   = clear_req && !in_clear;
    // clear_config raised while only activity was being cleared: restart the walk to wipe config too
    assign clr_restart = in_clear && clear_config && !clr_cfg;

    // Three free slots cover the two pipeline stages plus the op issued this cycle
    assign room      = f_cnt <= FCNT_W'(FIFO_DEPTH - 3);
    assign axon_rdy  = !reset && room && !in_clear;
    assign fire_acc  = axon_vld && axon_rdy;
    assign scan_iss  = (state == SCAN) && enable && room && !fire_acc;
    assign iss_vld   = fire_acc || scan_iss;
    assign iss_addr  = fire_acc ? axon_addr : scan_idx;
    assign last_scan = scan_idx == AXON_W'(NUM_AXONS - 1);
    assign drain_idle = !s1_vld && !s2_vld && (f_cnt == '0) && !fire_acc;
    assign clear_done = (state == CLEAR_DONE) && clear_req;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (next_step) state_nxt = SCAN;
            SCAN:       if (scan_iss && last_scan) state_nxt = DRAIN;
            DRAIN:      if (drain_idle) state_nxt = IDLE;
            CLEAR:      if (clr_idx == AXON_W'(NUM_AXONS - 1) && !clr_restart) state_nxt = CLEAR_DONE;
            CLEAR_DONE: if (clr_restart) state_nxt = CLEAR;
                        else if (!clear_req) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
        if (clr_entry) state_nxt = CLEAR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            scan_idx  <= '0;
            clr_idx   <= '0;
            clr_cfg   <= 1'b0;
            step_done <= 1'b0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            f_wr      <= '0;
            f_rd      <= '0;
            f_cnt     <= '0;
        end else begin
            state     <= state_nxt;
            step_done <= (state == DRAIN) && (state_nxt == IDLE);
            if (state != SCAN)
                scan_idx <= '0;
            else if (scan_iss)
                scan_idx <= scan_idx + AXON_W'(1);
            if (clr_entry || clr_restart) begin
                clr_idx <= '0;
                clr_cfg <= clear_config;
            end else if (state == CLEAR) begin
                clr_idx <= clr_idx + AXON_W'(1);
            end
            s1_vld <= iss_vld && !clear_req;
            s2_vld <= s1_vld && s1_push && !clear_req;
            if (clear_req) begin
                f_wr  <= '0;
                f_rd  <= '0;
                f_cnt <= '0;
            end else begin
                if (s2_vld) f_wr <= f_wr + PTR_W'(1);
                if (f_pop)  f_rd <= f_rd + PTR_W'(1);
                f_cnt <= f_cnt + FCNT_W'(s2_vld) - FCNT_W'(f_pop);
            end
        end
    end

    // Read stage; a same-axon op still in stage 1 supplies its pending write-back instead of RAM
    always_ff @(posedge clk) begin
        s1_cfg    <= cfg_ram[iss_addr];
        s1_dq     <= (s1_vld && s1_addr == iss_addr) ? s1_dq_new : dq_ram[iss_addr];
        s1_addr   <= iss_addr;
        s1_fire   <= fire_acc;
        s1_passed <= (state != SCAN) || (axon_addr < scan_idx);
        s2_start  <= s1_first;
        s2_end    <= s1_first + SYN_W'(s1_cnt) - SYN_W'(1);
    end

    always_comb begin
        {s1_delay, s1_first, s1_cnt} = s1_cfg;
        s1_dq_new = s1_dq;
        s1_push   = 1'b0;
        if (s1_fire) begin
            if (s1_delay == '0)
                s1_push = s1_cnt != '0;
            else if (s1_passed)
                s1_dq_new = s1_dq | (DQ_W'(1) << (s1_delay - DELAY_W'(1)));
            else
                s1_dq_new = s1_dq | (DQ_W'(1) << s1_delay);
        end else begin
            s1_push   = s1_dq[0] && (s1_cnt != '0);
            s1_dq_new = s1_dq >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            dq_ram[clr_idx] <= '0;
            if (clr_cfg) cfg_ram[clr_idx] <= '0;
        end else begin
            if (s1_vld) dq_ram[s1_addr] <= s1_dq_new;
            if (cfg_wr_en && state != CLEAR_DONE) cfg_ram[cfg_addr] <= cfg_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (s2_vld) begin
            f_start[f_wr] <= s2_start;
            f_end[f_wr]   <= s2_end;
        end
    end

    assign syn_vld   = f_cnt != '0;
    assign f_pop     = syn_vld && syn_rdy;
    assign syn_start = syn_vld ? f_start[f_rd] : '0;
    assign syn_end   = syn_vld ? f_end[f_rd] : '0;

`ifdef UCASPIAN_AXON_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || next_step || clear_req)
            fire_count <= '0;
        else if (s2_vld && fire_count != 16'hFFFF)
            fire_count <= fire_count + 16'd1;
    end
`endif
endmodule
